// File: rtl/dcache_tag_arbiter.sv
// dcache_tag_arbiter: arbitrates NR_PORTS requesters onto shared per-way tag/data SRAMs with a late tag compare
// Each way's line is packed {dirty, valid, tag, data} from MSB to LSB.
module dcache_tag_arbiter #(
  parameter int NR_PORTS    = 4,
  parameter int NR_WAYS     = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int BYTE_OFFSET = 4,
  parameter int TAG_WIDTH   = 44,
  parameter int LINE_WIDTH  = 128,
  parameter bit RR_MODE     = 1
) (
  input  logic                                                      clk_i,
  input  logic                                                      rst_ni,
  input  logic [NR_PORTS*NR_WAYS-1:0]                               req_i,
  input  logic [NR_PORTS*INDEX_WIDTH-1:0]                           addr_i,
  input  logic [NR_PORTS-1:0]                                       we_i,
  input  logic [NR_PORTS*(LINE_WIDTH+TAG_WIDTH+2)-1:0]              wdata_i,
  input  logic [NR_PORTS*(LINE_WIDTH/8+TAG_WIDTH/8+NR_WAYS)-1:0]    be_i,
  input  logic [NR_PORTS*TAG_WIDTH-1:0]                             tag_i,
  output logic [NR_PORTS-1:0]                                       gnt_o,
  output logic [NR_PORTS-1:0]                                       rvalid_o,
  output logic [NR_WAYS*(LINE_WIDTH+TAG_WIDTH+2)-1:0]               rdata_o,
  output logic [NR_WAYS-1:0]                                        hit_way_o,
  output logic                                                      multi_hit_o,
  output logic [NR_WAYS-1:0]                                        ram_req_o,
  output logic [INDEX_WIDTH-BYTE_OFFSET-1:0]                        ram_addr_o,
  output logic                                                      ram_we_o,
  output logic [LINE_WIDTH+TAG_WIDTH+1:0]                           ram_wdata_o,
  output logic [LINE_WIDTH/8+TAG_WIDTH/8+NR_WAYS-1:0]               ram_be_o,
  input  logic [NR_WAYS*(LINE_WIDTH+TAG_WIDTH+2)-1:0]               ram_rdata_i
);
  localparam int LW = LINE_WIDTH + TAG_WIDTH + 2;
  localparam int BW = LINE_WIDTH/8 + TAG_WIDTH/8 + NR_WAYS;
  localparam int IW = $clog2(NR_PORTS);
  localparam int AW = INDEX_WIDTH - BYTE_OFFSET;
  logic [IW-1:0]       rr_ptr_q, id_q, gid;
  logic                rd_q, vld_q, gnt_any;
  logic [NR_PORTS-1:0] req_any;
  // i-th candidate among ports 1..NR_PORTS-1, starting at the pointer in round-robin mode
  function automatic logic [IW-1:0] slot(input logic [IW-1:0] ptr, input int i);
    int p;
    p = RR_MODE ? int'(ptr) + i : i + 1;
    return IW'(p >= NR_PORTS ? p - (NR_PORTS - 1) : p);
  endfunction
  always_comb begin
    req_any = '0;
    for (int p = 0; p < NR_PORTS; p++) req_any[p] = |req_i[p*NR_WAYS +: NR_WAYS];
  end
  always_comb begin
    gid = '0;
    gnt_any = req_any[0];
    for (int i = 0; i < NR_PORTS - 1; i++) begin
      if (!gnt_any && req_any[slot(rr_ptr_q, i)]) begin
        gid = slot(rr_ptr_q, i);
        gnt_any = 1'b1;
      end
    end
  end
  always_comb begin
    gnt_o = gnt_any ? NR_PORTS'(1) << gid : '0;
    ram_req_o = gnt_any ? req_i[gid*NR_WAYS +: NR_WAYS] : '0;
    ram_addr_o = addr_i[gid*INDEX_WIDTH+BYTE_OFFSET +: AW];
    ram_we_o = gnt_any & we_i[gid];
    ram_wdata_o = wdata_i[gid*LW +: LW];
    ram_be_o = be_i[gid*BW +: BW];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= IW'(1);
      id_q <= '0;
      rd_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= gnt_any;
      if (gnt_any) begin
        id_q <= gid;
        rd_q <= !we_i[gid];
      end
      if (gnt_any && gid != '0) rr_ptr_q <= gid == IW'(NR_PORTS - 1) ? IW'(1) : gid + 1'b1;
    end
  end
  // The tag arrives a cycle late, so compare against the port captured at grant time
  always_comb begin
    hit_way_o = '0;
    for (int w = 0; w < NR_WAYS; w++)
      hit_way_o[w] = vld_q & rd_q & ram_rdata_i[w*LW+LINE_WIDTH+TAG_WIDTH]
                   & (ram_rdata_i[w*LW+LINE_WIDTH +: TAG_WIDTH] == tag_i[id_q*TAG_WIDTH +: TAG_WIDTH]);
    multi_hit_o = |(hit_way_o & (hit_way_o - 1'b1));
    rvalid_o = (vld_q & rd_q) ? NR_PORTS'(1) << id_q : '0;
  end
  assign rdata_o = ram_rdata_i;
endmodule

// File: tb/tb_dcache_tag_arbiter.sv
// tb_dcache_tag_arbiter: directed tests for both arbitration modes against a behavioural model
module tb_dcache_tag_arbiter;
  localparam int NP = 4, NW = 8, IX = 12, BO = 4, TW = 44, LW = 128;
  localparam int RW = LW + TW + 2, BW = LW/8 + TW/8 + NW, AW = IX - BO;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;
  logic [NW-1:0] req [NP];
  logic [IX-1:0] addr [NP];
  logic [NP-1:0] we;
  logic [RW-1:0] wdata [NP];
  logic [BW-1:0] be [NP];
  logic [TW-1:0] tag [NP];
  logic [NP*NW-1:0] req_f;
  logic [NP*IX-1:0] addr_f;
  logic [NP*RW-1:0] wdata_f;
  logic [NP*BW-1:0] be_f;
  logic [NP*TW-1:0] tag_f;
  logic [NW*RW-1:0] ram_rdata, rdata_o, rdata2;
  logic [RW-1:0] mem [NW][256];
  logic [RW-1:0] rd [NW];
  logic [NP-1:0] gnt_o, rvalid_o, gnt2, rvalid2;
  logic [NW-1:0] hit_way_o, ram_req_o, hit2, ram_req2;
  logic multi_hit_o, ram_we_o, multi2, ram_we2;
  logic [AW-1:0] ram_addr_o, ram_addr2;
  logic [RW-1:0] ram_wdata_o, ram_wdata2;
  logic [BW-1:0] ram_be_o, ram_be2;
  always_comb begin
    req_f = '0; addr_f = '0; wdata_f = '0; be_f = '0; tag_f = '0; ram_rdata = '0;
    for (int p = 0; p < NP; p++) begin
      req_f[p*NW +: NW] = req[p];
      addr_f[p*IX +: IX] = addr[p];
      wdata_f[p*RW +: RW] = wdata[p];
      be_f[p*BW +: BW] = be[p];
      tag_f[p*TW +: TW] = tag[p];
    end
    for (int w = 0; w < NW; w++) ram_rdata[w*RW +: RW] = rd[w];
  end
  dcache_tag_arbiter #(.NR_PORTS(NP), .NR_WAYS(NW), .INDEX_WIDTH(IX), .BYTE_OFFSET(BO),
    .TAG_WIDTH(TW), .LINE_WIDTH(LW), .RR_MODE(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_f), .addr_i(addr_f), .we_i(we), .wdata_i(wdata_f),
    .be_i(be_f), .tag_i(tag_f), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .hit_way_o(hit_way_o), .multi_hit_o(multi_hit_o), .ram_req_o(ram_req_o), .ram_addr_o(ram_addr_o),
    .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata));
  dcache_tag_arbiter #(.NR_PORTS(NP), .NR_WAYS(NW), .INDEX_WIDTH(IX), .BYTE_OFFSET(BO),
    .TAG_WIDTH(TW), .LINE_WIDTH(LW), .RR_MODE(0)) dut_fp (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_f), .addr_i(addr_f), .we_i(we), .wdata_i(wdata_f),
    .be_i(be_f), .tag_i(tag_f), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2),
    .hit_way_o(hit2), .multi_hit_o(multi2), .ram_req_o(ram_req2), .ram_addr_o(ram_addr2),
    .ram_we_o(ram_we2), .ram_wdata_o(ram_wdata2), .ram_be_o(ram_be2), .ram_rdata_i(ram_rdata));
  // SRAM behind the round-robin instance: one-cycle read latency, whole-line writes
  always @(posedge clk_i)
    for (int w = 0; w < NW; w++)
      if (ram_req_o[w]) begin
        if (ram_we_o) mem[w][ram_addr_o] <= ram_wdata_o;
        else rd[w] <= mem[w][ram_addr_o];
      end
  int tests = 0, fails = 0;
  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask
  function automatic int pick(input logic [NP-1:0] r, input int ptr, input bit rr);
    if (r[0]) return 0;
    for (int k = 0; k < NP - 1; k++) begin
      int p;
      p = rr ? 1 + (ptr - 1 + k) % (NP - 1) : 1 + k;
      if (r[p]) return p;
    end
    return -1;
  endfunction
  task automatic chk_port(input string n, input int g, input logic [NP-1:0] gn, input logic [NW-1:0] rq,
                          input logic [AW-1:0] ad, input logic w, input logic [RW-1:0] wd, input logic [BW-1:0] b);
    if (g < 0) begin
      chk({n, ".gnt"}, gn, 0);
      chk({n, ".ram_req"}, rq, 0);
    end else begin
      chk({n, ".gnt"}, gn, 256'(1) << g);
      chk({n, ".ram_req"}, rq, req[g]);
      chk({n, ".ram_addr"}, ad, addr[g][IX-1:BO]);
      chk({n, ".ram_we"}, w, we[g]);
      chk({n, ".ram_wdata"}, wd, wdata[g]);
      chk({n, ".ram_be"}, b, be[g]);
    end
  endtask
  int m_ptr = 1, m_id = 0, m2_id = 0;
  bit m_vld = 0, m_rd = 0, m2_vld = 0, m2_rd = 0;
  logic [AW-1:0] m_row = '0;
  always @(negedge rst_ni) begin
    m_vld = 0;
    m2_vld = 0;
    m_ptr = 1;
  end
  always @(negedge clk_i) begin
    logic [NP-1:0] r;
    logic [NW-1:0] eh, eh2;
    int g, g2;
    for (int p = 0; p < NP; p++) r[p] = |req[p];
    g = pick(r, m_ptr, 1);
    g2 = pick(r, 0, 0);
    chk_port("rr", g, gnt_o, ram_req_o, ram_addr_o, ram_we_o, ram_wdata_o, ram_be_o);
    chk_port("fp", g2, gnt2, ram_req2, ram_addr2, ram_we2, ram_wdata2, ram_be2);
    eh = '0;
    eh2 = '0;
    for (int w = 0; w < NW; w++) begin
      if (m_vld && m_rd) eh[w] = mem[w][m_row][LW+TW] && mem[w][m_row][LW +: TW] == tag[m_id];
      if (m2_vld && m2_rd) eh2[w] = rd[w][LW+TW] && rd[w][LW +: TW] == tag[m2_id];
      chk("rr.rdata", rdata_o[w*RW +: RW], rd[w]);
      chk("fp.rdata", rdata2[w*RW +: RW], rd[w]);
    end
    chk("rr.rvalid", rvalid_o, (m_vld && m_rd) ? 256'(1) << m_id : 0);
    chk("rr.hit", hit_way_o, eh);
    chk("rr.multi", multi_hit_o, $countones(eh) > 1);
    chk("fp.rvalid", rvalid2, (m2_vld && m2_rd) ? 256'(1) << m2_id : 0);
    chk("fp.hit", hit2, eh2);
    chk("fp.multi", multi2, $countones(eh2) > 1);
    if (!rst_ni) begin
      m_vld = 0;
      m2_vld = 0;
      m_ptr = 1;
    end else begin
      m_vld = g >= 0;
      m2_vld = g2 >= 0;
      if (g >= 0) begin
        m_id = g;
        m_rd = !we[g];
        m_row = addr[g][IX-1:BO];
        if (g > 0) m_ptr = g % (NP - 1) + 1;
      end
      if (g2 >= 0) begin
        m2_id = g2;
        m2_rd = !we[g2];
      end
    end
  end
  task automatic go;
    @(posedge clk_i);
    #1;
  endtask
  task automatic put(input int p, input logic [NW-1:0] m, input logic [IX-1:0] a, input logic w,
                     input logic [TW-1:0] t, input logic v);
    req[p] = m;
    addr[p] = a;
    we[p] = w;
    tag[p] = t;
    be[p] = '1;
    wdata[p] = {1'b0, v, t, {4{24'hC0FFEE, 8'(p)}}};
  endtask
  task automatic idle(input int p);
    req[p] = '0;
    we[p] = 1'b0;
  endtask
  task automatic wr(input int p, input logic [NW-1:0] m, input logic [IX-1:0] a, input logic [TW-1:0] t, input logic v);
    put(p, m, a, 1'b1, t, v);
    go;
    idle(p);
  endtask
  task automatic do_reset;
    for (int p = 0; p < NP; p++) idle(p);
    rst_ni = 1'b0;
    go;
    go;
    rst_ni = 1'b1;
  endtask
  int ord [6];
  initial begin
    ord = '{1, 2, 3, 1, 2, 3};
    for (int p = 0; p < NP; p++) put(p, '0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst.gnt", gnt_o, 0);
    chk("rst.rvalid", rvalid_o, 0);
    chk("rst.hit", hit_way_o, 0);
    chk("rst.multi", multi_hit_o, 0);
    chk("rst.ram_req", ram_req_o, 0);
    chk("rst.ptr", dut.rr_ptr_q, 1);
    go;
    rst_ni = 1'b1;
    wr(0, 8'hFF, 12'h040, '0, 1'b0);
    wr(0, 8'h04, 12'h040, 44'h123, 1'b1);
    put(1, 8'hFF, 12'h040, 1'b0, 44'h123, 1'b0);
    @(negedge clk_i);
    chk("t1.gnt", gnt_o, 4'b0010);
    go;
    idle(1);
    @(negedge clk_i);
    chk("t1.rvalid", rvalid_o, 4'b0010);
    chk("t1.hit", hit_way_o, 8'h04);
    chk("t1.multi", multi_hit_o, 0);
    go;
    do_reset;
    put(0, 8'hFF, 12'h040, 1'b0, 44'h123, 1'b0);
    put(1, 8'hFF, 12'h040, 1'b0, 44'h123, 1'b0);
    put(3, 8'hFF, 12'h040, 1'b0, 44'h123, 1'b0);
    @(negedge clk_i);
    chk("t2.gnt0", gnt_o, 4'b0001);
    go;
    idle(0);
    @(negedge clk_i);
    chk("t2.gnt1", gnt_o, 4'b0010);
    chk("t2.ptr0", dut.rr_ptr_q, 1);
    go;
    idle(1);
    @(negedge clk_i);
    chk("t2.gnt3", gnt_o, 4'b1000);
    chk("t2.ptr1", dut.rr_ptr_q, 2);
    go;
    idle(3);
    @(negedge clk_i);
    chk("t2.ptr3", dut.rr_ptr_q, 1);
    chk("t2.idle", gnt_o, 0);
    go;
    do_reset;
    for (int p = 1; p < NP; p++) put(p, 8'hFF, 12'h040, 1'b0, 44'h123, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("t3.rr_gnt", gnt_o, 256'(1) << ord[i]);
      chk("t3.fp_gnt", gnt2, 4'b0010);
      go;
    end
    for (int p = 1; p < NP; p++) idle(p);
    go;
    put(2, 8'hFF, 12'h080, 1'b1, 44'h123, 1'b1);
    @(negedge clk_i);
    chk("t4.wr_gnt", gnt_o, 4'b0100);
    go;
    put(2, 8'hFF, 12'h080, 1'b0, 44'h123, 1'b0);
    @(negedge clk_i);
    chk("t4.rd_gnt", gnt_o, 4'b0100);
    chk("t4.wr_rvalid", rvalid_o, 0);
    go;
    idle(2);
    @(negedge clk_i);
    chk("t4.rvalid", rvalid_o, 4'b0100);
    chk("t4.hit", hit_way_o, 8'hFF);
    chk("t4.multi", multi_hit_o, 1);
    chk("t4.ptr", dut.rr_ptr_q, 3);
    go;
    put(1, 8'hFF, 12'h040, 1'b0, 44'h123, 1'b0);
    @(negedge clk_i);
    chk("t5.gnt", gnt_o, 4'b0010);
    #1 rst_ni = 1'b0;
    go;
    idle(1);
    @(negedge clk_i);
    chk("t5.rvalid", rvalid_o, 0);
    chk("t5.hit", hit_way_o, 0);
    go;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("t5.ptr", dut.rr_ptr_q, 1);
    go;
    wr(0, 8'hFF, 12'h0C0, 44'h123, 1'b1);
    put(3, 8'hFF, 12'h0C0, 1'b0, 44'h555, 1'b0);
    @(negedge clk_i);
    chk("t6.gnt", gnt_o, 4'b1000);
    go;
    idle(3);
    @(negedge clk_i);
    chk("t6.miss_rvalid", rvalid_o, 4'b1000);
    chk("t6.miss_hit", hit_way_o, 0);
    go;
    wr(0, 8'hFF, 12'h0D0, 44'h555, 1'b0);
    put(1, 8'hFF, 12'h0D0, 1'b0, 44'h555, 1'b0);
    go;
    idle(1);
    @(negedge clk_i);
    chk("t6.inv_rvalid", rvalid_o, 4'b0010);
    chk("t6.inv_hit", hit_way_o, 0);
    repeat (2) go;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
